writeback_arbiter: RTL and testbench

Merges ALU and load-unit results onto the single write port of the register file (`waddr`/`wdata`/`wen`) and sits directly upstream of it. The ALU path can never stall; load results that collide with an ALU write are buffered in a small FIFO and retired in order. Younger ALU writes to the same destination squash queued loads. A pending-destination mask is exported for upstream hazard logic.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_load_fifo.sv | 78 +++++++
 rtl/writeback_arbiter.sv | 122 ++++++++++++
 tb/tb_writeback_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and the load-queue entry layout for the writeback arbiter.
package wb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_AW   = 5;

    // Default-width entry; the FIFO declares the same layout at its own XLEN.
    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular load buffer with per-entry live bits, a destination squash port
// and a live/rd view of every slot for pending-destination mask generation.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     push_live,
    input  logic [REG_AW-1:0]        push_rd,
    input  logic [XLEN-1:0]          push_data,
    input  logic                     pop,
    input  logic                     squash_en,
    input  logic [REG_AW-1:0]        squash_rd,
    output logic                     head_live,
    output logic [REG_AW-1:0]        head_rd,
    output logic [XLEN-1:0]          head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         live_vec,
    output logic [REG_AW-1:0]        rd_vec [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // The push slot is always free (no push when full) and differs from the
    // popped slot, so the squash, pop-clear and push writes never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && mem[i].live && (mem[i].rd == squash_rd)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr] <= '{live: push_live, rd: push_rd, data: push_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_live = mem[rd_ptr].live;
    assign head_rd   = mem[rd_ptr].rd;
    assign head_data = mem[rd_ptr].data;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live_vec[i] = mem[i].live;
            rd_vec[i]   = mem[i].rd;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the single register-file write port; ALU
// never stalls, colliding loads queue in order and are squashed by younger ALU writes.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [REG_AW-1:0]       alu_rd,
    input  logic [XLEN-1:0]         alu_result,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [REG_AW-1:0]       ld_rd,
    input  logic [XLEN-1:0]         ld_data,
    output logic                    rf_wen,
    output logic [REG_AW-1:0]       rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [31:0]             pend_rd_mask,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Load handshake: a transfer happens on every edge where ld_valid && ld_ready;
    // ld_ready depends only on occupancy and reset, never on either valid.
    logic alu_hit, ld_acc, ld_keep, fifo_empty;

    logic              push, push_live, pop, squash_en;
    logic              issue;
    logic [REG_AW-1:0] issue_rd;
    logic [XLEN-1:0]   issue_data;

    logic              head_live;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;
    logic [DEPTH-1:0]  live_vec;
    logic [REG_AW-1:0] rd_vec [DEPTH];

    assign ld_ready   = !rst && (fifo_count < CW'(DEPTH));
    assign alu_hit    = alu_valid && (alu_rd != '0);
    assign ld_acc     = ld_valid && ld_ready;
    assign ld_keep    = ld_acc && (ld_rd != '0);
    assign fifo_empty = (fifo_count == '0);

    always_comb begin
        push       = 1'b0;
        push_live  = 1'b1;
        pop        = 1'b0;
        squash_en  = 1'b0;
        issue      = 1'b0;
        issue_rd   = '0;
        issue_data = '0;
        if (alu_hit) begin
            issue      = 1'b1;
            issue_rd   = alu_rd;
            issue_data = alu_result;
            squash_en  = 1'b1;
            push       = ld_keep;
            // A concurrent load is always older, so the ALU write wins.
            push_live  = (ld_rd != alu_rd);
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            issue      = head_live;
            issue_rd   = head_rd;
            issue_data = head_data;
            push       = ld_keep;
        end else if (ld_keep) begin
            issue      = 1'b1;
            issue_rd   = ld_rd;
            issue_data = ld_data;
        end
    end

    wb_load_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_live (push_live),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (pop),
        .squash_en (squash_en),
        .squash_rd (alu_rd),
        .head_live (head_live),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (fifo_count),
        .live_vec  (live_vec),
        .rd_vec    (rd_vec)
    );

    // Decoded straight from FIFO registers, so it reflects the state after each edge.
    always_comb begin
        pend_rd_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_vec[i]) begin
                pend_rd_mask[rd_vec[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= issue;
            if (issue) begin
                rf_waddr <= issue_rd;
                rf_wdata <= issue_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based model.
module tb_writeback_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_result = '0;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic [4:0]      ld_rd = '0;
    logic [XLEN-1:0] ld_data = '0;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     pend_rd_mask;
    logic [CW-1:0]   fifo_count;

    writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_result   (alu_result),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pend_rd_mask (pend_rd_mask),
        .fifo_count   (fifo_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected register-file writes, {rd, data}
    logic [5+XLEN-1:0] exp_q[$];

    // reference model: the load queue as an ordered list of pending loads
    typedef struct {
        bit              live;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ref_t;
    ref_t ref_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_mask();
        logic [31:0] m = '0;
        foreach (ref_q[i]) if (ref_q[i].live) m[ref_q[i].rd] = 1'b1;
        return m;
    endfunction

    // scoreboard monitor: every write the DUT presents must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rf_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
            end else begin
                check("write", {27'd0, rf_waddr, rf_wdata}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // driver: one cycle of stimulus plus the model's view of that cycle
    task automatic step(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ares,
                        input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat);
        bit   a, rdy, keep;
        ref_t h;
        @(negedge clk);
        #2;
        check("fifo_count", 64'(fifo_count), 64'(ref_q.size()));
        check("pend_rd_mask", 64'(pend_rd_mask), 64'(ref_mask()));
        alu_valid = av; alu_rd = ard; alu_result = ares;
        ld_valid  = lv; ld_rd  = lrd; ld_data    = ldat;
        #1;
        rdy = (ref_q.size() < DEPTH);
        check("ld_ready", 64'(ld_ready), 64'(rdy));
        a    = av && (ard != 0);
        keep = lv && rdy && (lrd != 0);
        if (a) begin
            exp_q.push_back({ard, ares});
            foreach (ref_q[i]) if (ref_q[i].rd == ard) ref_q[i].live = 0;
            if (keep) ref_q.push_back('{live: (lrd != ard), rd: lrd, data: ldat});
        end else if (ref_q.size() > 0) begin
            h = ref_q.pop_front();
            if (h.live) exp_q.push_back({h.rd, h.data});
            if (keep) ref_q.push_back('{live: 1'b1, rd: lrd, data: ldat});
        end else if (keep) begin
            exp_q.push_back({lrd, ldat});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, '0, 0, 5'd0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        alu_valid = 0; ld_valid = 0;
        #4;
        rst = 1'b1;
        #1;
        check("rst_wen", 64'(rf_wen), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_mask", 64'(pend_rd_mask), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        ref_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check("init_wen", 64'(rf_wen), 64'd0);
        check("init_ld_ready", 64'(ld_ready), 64'd0);
        #11;
        rst = 1'b0;

        // basic ALU write
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, '0);
        idle(1);
        // ALU and load collide; load retires next idle cycle
        step(1, 5'd3, 32'h0000_0333, 1, 5'd7, 32'h11);
        idle(2);
        // ALU busy while loads queue up and back-pressure engages
        step(1, 5'd10, 32'hA0, 1, 5'd1, 32'h101);
        step(1, 5'd11, 32'hA1, 1, 5'd2, 32'h102);
        step(1, 5'd12, 32'hA2, 1, 5'd3, 32'h103);
        step(1, 5'd13, 32'hA3, 1, 5'd3, 32'h103);
        step(0, 5'd0, '0, 1, 5'd3, 32'h103);
        step(0, 5'd0, '0, 1, 5'd3, 32'h103);
        idle(3);
        // younger ALU write squashes a queued load
        step(1, 5'd20, 32'hB0, 1, 5'd9, 32'h99);
        step(1, 5'd9, 32'h5, 0, 5'd0, '0);
        idle(2);
        // x0 filtering
        step(1, 5'd0, 32'hFFFF, 1, 5'd4, 32'h44);
        step(0, 5'd0, '0, 1, 5'd0, 32'h55);
        idle(1);
        // async reset with two entries queued
        step(1, 5'd21, 32'hC0, 1, 5'd22, 32'hC2);
        step(1, 5'd23, 32'hC1, 1, 5'd24, 32'hC4);
        do_reset();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(6);
        @(negedge clk);
        #2;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
